// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port line arbiter: FSM states, port ids and the
// round-robin winner selection used when both caches request together.
package mem_arbiter_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_S0 = 1'b0,
        PORT_S1 = 1'b1
    } port_id_t;

    // A lone requester always wins; on a tie the port not granted last wins.
    function automatic port_id_t pick_winner(input logic v0, input logic v1,
                                             input port_id_t last);
        port_id_t w;
        if (v0 && v1) begin
            w = (last == PORT_S1) ? PORT_S0 : PORT_S1;
        end else if (v1) begin
            w = PORT_S1;
        end else begin
            w = PORT_S0;
        end
        return w;
    endfunction

endpackage

// File: rtl/memory_interface.sv
// Line-granular memory port: a master raises valid while ready=1, the slave
// drops ready while busy and raises it again with rd_data on completion.
interface memory_interface #(
    parameter int LINE_SIZE = 256,
    parameter int ADDR_SIZE = 32
) ();
    logic [ADDR_SIZE-1:0] addr;
    logic [LINE_SIZE-1:0] wr_data;
    logic [LINE_SIZE-1:0] rd_data;
    logic                 write;
    logic                 valid;
    logic                 ready;

    modport master (output addr, output wr_data, output write, output valid,
                    input rd_data, input ready);
    modport slave  (input addr, input wr_data, input write, input valid,
                    output rd_data, output ready);
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction-cache (s0) and data-cache (s1) line ports onto a
// single main-memory port with a round-robin tie break.
module mem_arbiter
    import mem_arbiter_types::*;
#(
    parameter int LINE_SIZE = 256,
    parameter int ADDR_SIZE = 32
) (
    input logic             clk_i,
    input logic             reset_i,
    memory_interface.slave  s0_bus,
    memory_interface.slave  s1_bus,
    memory_interface.master memory_bus
);

    arb_state_t           state;
    arb_state_t           state_next;
    port_id_t             grant;
    port_id_t             last_grant;
    port_id_t             winner;
    logic                 accept;
    logic [ADDR_SIZE-1:0] req_addr;
    logic [LINE_SIZE-1:0] req_wr_data;
    logic                 req_write;

    assign winner = pick_winner(s0_bus.valid, s1_bus.valid, last_grant);
    assign accept = (state == IDLE) && memory_bus.ready
                    && (s0_bus.valid || s1_bus.valid);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            last_grant  <= PORT_S1;
            grant       <= PORT_S0;
            req_addr    <= '0;
            req_wr_data <= '0;
            req_write   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                grant       <= winner;
                req_addr    <= (winner == PORT_S1) ? s1_bus.addr    : s0_bus.addr;
                req_wr_data <= (winner == PORT_S1) ? s1_bus.wr_data : s0_bus.wr_data;
                req_write   <= (winner == PORT_S1) ? s1_bus.write   : s0_bus.write;
            end
            // The pointer only moves once the granted transaction has completed.
            if ((state == WAIT) && memory_bus.ready) begin
                last_grant <= grant;
            end
        end
    end

    always_comb begin
        state_next         = state;
        memory_bus.valid   = 1'b0;
        memory_bus.addr    = '0;
        memory_bus.wr_data = '0;
        memory_bus.write   = 1'b0;
        s0_bus.ready       = memory_bus.ready;
        s1_bus.ready       = memory_bus.ready;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                memory_bus.valid   = 1'b1;
                memory_bus.addr    = req_addr;
                memory_bus.wr_data = req_wr_data;
                memory_bus.write   = req_write;
                s0_bus.ready       = (grant != PORT_S0);
                s1_bus.ready       = (grant != PORT_S1);
                if (!memory_bus.ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                memory_bus.addr    = req_addr;
                memory_bus.wr_data = req_wr_data;
                memory_bus.write   = req_write;
                s0_bus.ready       = (grant == PORT_S0) ? memory_bus.ready : 1'b1;
                s1_bus.ready       = (grant == PORT_S1) ? memory_bus.ready : 1'b1;
                if (memory_bus.ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Both ports see the memory line; only the granted port's ready qualifies it.
    assign s0_bus.rd_data = memory_bus.rd_data;
    assign s1_bus.rd_data = memory_bus.rd_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small busy-counting memory model.
module tb_mem_arbiter;

    localparam int LW   = 256;
    localparam int AW   = 32;
    localparam int BUSY = 5;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk = ~clk;

    memory_interface #(.LINE_SIZE(LW), .ADDR_SIZE(AW)) s0_if ();
    memory_interface #(.LINE_SIZE(LW), .ADDR_SIZE(AW)) s1_if ();
    memory_interface #(.LINE_SIZE(LW), .ADDR_SIZE(AW)) mem_if ();

    mem_arbiter #(.LINE_SIZE(LW), .ADDR_SIZE(AW)) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .s0_bus     (s0_if.slave),
        .s1_bus     (s1_if.slave),
        .memory_bus (mem_if.master)
    );

    function automatic logic [LW-1:0] line_for(input logic [AW-1:0] a);
        if (a == 32'h0000_1000) return {32{8'hA5}};
        return {8{a}};
    endfunction

    // Memory model: ready drops as soon as valid is seen, stays low BUSY cycles.
    int          busy_cnt = 0;
    logic [LW-1:0] mem_rd = '0;
    logic        mem_hold = 1'b0;
    always @(posedge clk) begin
        if (mem_if.valid && busy_cnt == 0 && !mem_hold) begin
            busy_cnt <= BUSY;
            mem_rd   <= line_for(mem_if.addr);
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign mem_if.ready   = (busy_cnt == 0) && !mem_if.valid && !mem_hold;
    assign mem_if.rd_data = mem_rd;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    logic [AW-1:0] log_addr[$];
    logic          log_write[$];
    logic [LW-1:0] log_wdata[$];
    int            log_cyc[$];
    logic [LW-1:0] s0_rd[$];
    logic [LW-1:0] s1_rd[$];
    int            s0_rise_cyc[$];
    int            s0_low = 0;
    int            s1_low = 0;
    logic          s0_prev = 1'b0;
    logic          s1_prev = 1'b0;

    task automatic check(input string tag, input logic [LW-1:0] obs,
                         input logic [LW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_at(input int k);
        if (k < log_addr.size()) return log_addr[k];
        return 'x;
    endfunction

    function automatic logic [LW-1:0] rd_at(input logic [LW-1:0] q[$], input int k);
        if (k < q.size()) return q[k];
        return 'x;
    endfunction

    task automatic start_test();
        log_addr.delete(); log_write.delete(); log_wdata.delete(); log_cyc.delete();
        s0_rd.delete(); s1_rd.delete(); s0_rise_cyc.delete();
        s0_low = 0;
        s1_low = 0;
        s0_prev = s0_if.ready;
        s1_prev = s1_if.ready;
    endtask

    // One clock: log memory issues, track ready edges, masters drop valid on ready fall.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mem_if.valid) begin
            log_addr.push_back(mem_if.addr);
            log_write.push_back(mem_if.write);
            log_wdata.push_back(mem_if.wr_data);
            log_cyc.push_back(cyc);
        end
        if (!s0_if.ready) s0_low++;
        if (!s1_if.ready) s1_low++;
        if (s0_prev && !s0_if.ready && s0_if.valid) s0_if.valid = 1'b0;
        if (s1_prev && !s1_if.ready && s1_if.valid) s1_if.valid = 1'b0;
        if (!s0_prev && s0_if.ready) begin
            s0_rd.push_back(s0_if.rd_data);
            s0_rise_cyc.push_back(cyc);
        end
        if (!s1_prev && s1_if.ready) s1_rd.push_back(s1_if.rd_data);
        s0_prev = s0_if.ready;
        s1_prev = s1_if.ready;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic s0_again;
        logic s1_again;
        s0_if.addr = '0; s0_if.wr_data = '0; s0_if.write = 1'b0; s0_if.valid = 1'b0;
        s1_if.addr = '0; s1_if.wr_data = '0; s1_if.write = 1'b0; s1_if.valid = 1'b0;

        // Reset state
        #2;
        check("rst_mem_valid", LW'(mem_if.valid), LW'(0));
        check("rst_mem_write", LW'(mem_if.write), LW'(0));
        check("rst_mem_addr", LW'(mem_if.addr), LW'(0));
        check("rst_s0_ready", LW'(s0_if.ready), LW'(1));
        check("rst_s1_ready", LW'(s1_if.ready), LW'(1));
        @(posedge clk);
        #1;
        reset_i = 1'b0;

        // Tie after reset, then two more ties formed by a completing port re-requesting
        start_test();
        s0_if.addr = 32'h100; s0_if.valid = 1'b1;
        s1_if.addr = 32'h200; s1_if.valid = 1'b1;
        s0_again = 1'b0;
        s1_again = 1'b0;
        for (int i = 0; i < 200 && s1_rd.size() < 2; i++) begin
            tick();
            if (s0_rd.size() == 1 && !s0_again) begin
                s0_again = 1'b1; s0_if.addr = 32'h300; s0_if.valid = 1'b1;
            end
            if (s1_rd.size() == 1 && !s1_again) begin
                s1_again = 1'b1; s1_if.addr = 32'h400; s1_if.valid = 1'b1;
            end
        end
        check("rr_pulses", LW'(log_addr.size()), LW'(4));
        check("rr_first_s0", LW'(addr_at(0)), LW'(32'h100));
        check("rr_second_s1", LW'(addr_at(1)), LW'(32'h200));
        check("rr_third_s0", LW'(addr_at(2)), LW'(32'h300));
        check("rr_fourth_s1", LW'(addr_at(3)), LW'(32'h400));
        check("rr_s1_next_idle", LW'((log_cyc.size() > 1 && s0_rise_cyc.size() > 0)
              ? (log_cyc[1] - s0_rise_cyc[0]) : -1), LW'(2));
        check("rr_s0_rd0", rd_at(s0_rd, 0), {8{32'h100}});
        check("rr_s1_rd0", rd_at(s1_rd, 0), {8{32'h200}});
        check("rr_s1_rd1", rd_at(s1_rd, 1), {8{32'h400}});
        repeat (2) tick();

        // s0 line fill
        start_test();
        s0_if.addr = 32'h0000_1000; s0_if.write = 1'b0; s0_if.valid = 1'b1;
        for (int i = 0; i < 50 && s0_rd.size() < 1; i++) tick();
        repeat (2) tick();
        check("fill_pulses", LW'(log_addr.size()), LW'(1));
        check("fill_addr", LW'(addr_at(0)), LW'(32'h1000));
        check("fill_write", LW'(log_write.size() > 0 ? log_write[0] : 1'bx), LW'(0));
        check("fill_s0_low", LW'(s0_low), LW'(6));
        check("fill_rd", rd_at(s0_rd, 0), {32{8'hA5}});
        check("fill_s1_low", LW'(s1_low), LW'(0));
        check("idle_addr_zero", LW'(mem_if.addr), LW'(0));

        // s1 writeback
        start_test();
        s1_if.addr = 32'h0000_2000; s1_if.wr_data = {16{16'hDEAD}};
        s1_if.write = 1'b1; s1_if.valid = 1'b1;
        for (int i = 0; i < 50 && s1_rd.size() < 1; i++) tick();
        repeat (2) tick();
        s1_if.write = 1'b0;
        check("wb_pulses", LW'(log_addr.size()), LW'(1));
        check("wb_addr", LW'(addr_at(0)), LW'(32'h2000));
        check("wb_write", LW'(log_write.size() > 0 ? log_write[0] : 1'bx), LW'(1));
        check("wb_wdata", log_wdata.size() > 0 ? log_wdata[0] : 'x, {16{16'hDEAD}});
        check("wb_s1_rise", LW'(s1_rd.size()), LW'(1));
        check("wb_s1_low", LW'(s1_low), LW'(6));
        check("wb_s0_low", LW'(s0_low), LW'(0));

        // Memory not ready in IDLE: request must wait
        mem_hold = 1'b1;
        #1;
        start_test();
        s0_if.addr = 32'h3000; s0_if.valid = 1'b1;
        repeat (4) tick();
        check("hold_no_issue", LW'(log_addr.size()), LW'(0));
        check("hold_s0_ready", LW'(s0_if.ready), LW'(0));
        mem_hold = 1'b0;
        #1;
        s0_prev = s0_if.ready;
        for (int i = 0; i < 50 && s0_rd.size() < 1; i++) tick();
        check("hold_pulses", LW'(log_addr.size()), LW'(1));
        check("hold_addr", LW'(addr_at(0)), LW'(32'h3000));
        repeat (2) tick();

        // Asynchronous reset in WAIT, then a normal request
        start_test();
        s0_if.addr = 32'h5000; s0_if.valid = 1'b1;
        repeat (3) tick();
        check("wait_addr_held", LW'(mem_if.addr), LW'(32'h5000));
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_valid", LW'(mem_if.valid), LW'(0));
        check("arst_addr", LW'(mem_if.addr), LW'(0));
        check("arst_s0_follows", LW'(s0_if.ready), LW'(mem_if.ready));
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        for (int i = 0; i < 20 && !s0_if.ready; i++) tick();
        check("arst_ready_back", LW'(s0_if.ready), LW'(1));
        start_test();
        s0_if.addr = 32'h6000; s0_if.valid = 1'b1;
        for (int i = 0; i < 50 && s0_rd.size() < 1; i++) tick();
        check("post_rst_pulses", LW'(log_addr.size()), LW'(1));
        check("post_rst_addr", LW'(addr_at(0)), LW'(32'h6000));
        check("post_rst_rd", rd_at(s0_rd, 0), {8{32'h6000}});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: LINE_SIZE, default 256, line width in bits; ADDR_SIZE, default 32, address width in bits.
REQ-002 Port clk_i SHALL be input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port reset_i SHALL be input, 1 bit; reset is asynchronous and active-high.
REQ-004 Port s0_bus SHALL be memory_interface.slave, the instruction-cache line port: addr ADDR_SIZE, wr_data/rd_data LINE_SIZE, write, valid, ready.
REQ-005 Port s1_bus SHALL be memory_interface.slave, the data-cache line port, with the same signals as s0_bus.
REQ-006 Port memory_bus SHALL be memory_interface.master, the single shared port to main memory, with the same signals.

Function
REQ-007 Protocol on every port: a master issues only while ready=1 and holds valid=1 until ready falls; the slave drops ready while busy and raises it on completion; rd_data is valid in the cycle ready returns high.
REQ-008 States SHALL be IDLE, ISSUE and WAIT.
REQ-009 IDLE: s0_bus.ready = s1_bus.ready = memory_bus.ready; memory_bus.valid=0.
REQ-010 IDLE -> ISSUE when memory_bus.ready=1 and any slave valid=1; addr, wr_data, write and the winning port id SHALL be latched that edge.
REQ-011 A single requester always wins. On simultaneous valid, the port not granted last SHALL win (round-robin); last_grant resets to 1, so s0 wins the first tie.
REQ-012 ISSUE: memory_bus.valid=1 with latched addr/wr_data/write; granted port ready=0; other port ready=1. ISSUE -> WAIT when memory_bus.ready=0.
REQ-013 WAIT: memory_bus.valid=0, addr/wr_data/write held; granted ready = memory_bus.ready; other ready=1. WAIT -> IDLE when memory_bus.ready=1; last_grant updated that edge.
REQ-014 s0_bus.rd_data and s1_bus.rd_data SHALL both be driven combinationally from memory_bus.rd_data; only the granted port's ready marks it valid.
REQ-015 The losing requester SHALL NOT be dropped: its valid stays high, and it is accepted in the IDLE cycle after the winner completes.
REQ-016 Arbitration latency: one request accepted at most once per IDLE visit; minimum turnaround is ISSUE 1 cycle plus memory busy time plus 1 IDLE cycle.
REQ-017 The memory_bus.addr/wr_data/write values SHALL be 0 in IDLE.

Reset
REQ-018 On reset_i=1, asynchronously: state=IDLE, last_grant=1, latched request=0, memory_bus.valid=0, memory_bus.write=0.
REQ-019 Reset mid-ISSUE or mid-WAIT SHALL abandon the transaction with no response to either port; after reset, ready follows memory_bus.ready.

Structure
REQ-020 The state enum (arb_state_t) and the port-id type SHALL live in a shared package mem_arbiter_types; the memory_interface definition is reused unchanged.
REQ-021 No sub-module; the request latch, the FSM and the round-robin pointer SHALL be in one module.

Verification
REQ-022 s0 fill only, addr 0x0000_1000; memory busy for 5 cycles, returns line 0xA5 pattern -> memory_bus sees addr 0x1000, write=0, one valid pulse; s0 ready low 6 cycles; s0 rd_data = 0xA5 pattern when ready rises.
REQ-023 s0 and s1 valid in the same cycle after reset -> s0 served first; s1 holds valid, is accepted in the next IDLE, and its addr appears on memory_bus second.
REQ-024 Second simultaneous tie right after the REQ-023 sequence -> s1 wins (round-robin); third tie -> s0 wins.
REQ-025 s1 writeback to addr 0x0000_2000, wr_data 0xDEAD pattern -> memory_bus write=1, wr_data matches, valid for 1 cycle; s1 ready returns high when memory ready rises.
REQ-026 memory_bus.ready=0 while s0 valid=1 in IDLE -> no acceptance; state stays IDLE until memory ready rises.
REQ-027 reset_i asserted during WAIT -> memory_bus.valid=0 and state=IDLE immediately, without waiting for a clock edge; the next s0 request is served normally.
